// File: rtl/fifo_rd_stream.sv
// rtl/fifo_rd_stream.sv - FIFO read-side drain into a 2-entry skid buffered stream with burst framing
// Pops never depend on out_ready; the skid buffer absorbs the one word in flight when backpressure hits.
module fifo_rd_stream #(
  parameter int DATA_SIZE = 8,
  parameter int BURST_LEN = 16,
  parameter int CNT_SIZE  = 16
) (
  input  logic                 rd_clk,
  input  logic                 rd_rst_n,
  input  logic                 fifo_empty,
  input  logic [DATA_SIZE-1:0] fifo_rd_data,
  output logic                 fifo_rd_en,
  input  logic                 hold,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [DATA_SIZE-1:0] out_data,
  output logic                 out_last,
  output logic [CNT_SIZE-1:0]  xfer_count,
  output logic                 burst_done
);

  localparam int IDX_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(BURST_LEN - 1);

  typedef enum logic [1:0] {S0, S1, S2} state_t;

  state_t               state;
  logic [DATA_SIZE-1:0] head_data;
  logic [DATA_SIZE-1:0] tail_data;
  logic                 head_last;
  logic                 tail_last;
  logic [IDX_W-1:0]     pop_idx;
  logic                 pop;
  logic                 accept;
  logic                 pop_last;

  // Reset gates the pop so the FIFO is never drained while we are held in reset.
  assign pop        = rd_rst_n & ~fifo_empty & ~hold & (state != S2);
  assign fifo_rd_en = pop;
  assign out_valid  = (state != S0);
  assign accept     = out_valid & out_ready;
  assign out_data   = head_data;
  assign out_last   = head_last & out_valid;
  assign pop_last   = (pop_idx == IDX_MAX);

  always_ff @(posedge rd_clk or negedge rd_rst_n) begin
    if (!rd_rst_n) begin
      state      <= S0;
      head_data  <= '0;
      head_last  <= 1'b0;
      tail_data  <= '0;
      tail_last  <= 1'b0;
      pop_idx    <= '0;
      xfer_count <= '0;
      burst_done <= 1'b0;
    end else begin
      if (pop) begin
        pop_idx <= pop_last ? '0 : pop_idx + IDX_W'(1);
      end
      if (accept) begin
        xfer_count <= xfer_count + CNT_SIZE'(1);
      end
      burst_done <= accept & out_last;

      case (state)
        S0: begin
          if (pop) begin
            head_data <= fifo_rd_data;
            head_last <= pop_last;
            state     <= S1;
          end
        end
        S1: begin
          if (pop && !accept) begin
            tail_data <= fifo_rd_data;
            tail_last <= pop_last;
            state     <= S2;
          end else if (pop && accept) begin
            head_data <= fifo_rd_data;
            head_last <= pop_last;
          end else if (accept) begin
            state <= S0;
          end
        end
        S2: begin
          if (accept) begin
            head_data <= tail_data;
            head_last <= tail_last;
            state     <= S1;
          end
        end
        default: state <= S0;
      endcase
    end
  end

endmodule
